// File: rtl/ifetch_if.sv
// ifetch_if: memory-controller fetch channel, redirect strobe and instruction slot.
interface ifetch_if;
    logic        mc_if_en;
    logic [31:0] mc_if_pc;
    logic [31:0] mc_if_data;
    logic        mc_if_done;
    logic        jump_en;
    logic [31:0] jump_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    modport master (
        output mc_if_en, mc_if_pc, inst_valid, inst_data, inst_pc,
        input  mc_if_data, mc_if_done, jump_en, jump_pc, inst_ready
    );
    modport slave (
        input  mc_if_en, mc_if_pc, inst_valid, inst_data, inst_pc,
        output mc_if_data, mc_if_done, jump_en, jump_pc, inst_ready
    );
endinterface

// File: rtl/ifetch.sv
// ifetch: instruction fetch with a direct-mapped one-word-per-line cache and single outstanding miss.
module ifetch #(
    parameter int          ICACHE_LINES = 16,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input logic      clk,
    input logic      rst,
    input logic      rdy,
    ifetch_if.master bus
);
    localparam int IDX = $clog2(ICACHE_LINES);
    localparam int TW  = 16 - IDX;
    typedef enum logic {RUN, MISS} state_t;
    state_t                  state_q, state_d;
    logic [31:0]             pc_q, pc_d, miss_addr_q, miss_addr_d;
    logic [31:0]             inst_data_q, inst_data_d, inst_pc_q, inst_pc_d;
    logic                    inst_valid_q, inst_valid_d;
    logic [31:0]             data_mem [ICACHE_LINES];
    logic [TW-1:0]           tag_mem [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] valid_q;
    logic [IDX-1:0]          pc_idx, miss_idx;
    logic [TW-1:0]           pc_tag, miss_tag;
    logic                    slot_free, hit, fill;
    assign pc_idx    = pc_q[IDX+1:2];
    assign pc_tag    = pc_q[17:IDX+2];
    assign miss_idx  = miss_addr_q[IDX+1:2];
    assign miss_tag  = miss_addr_q[17:IDX+2];
    assign slot_free = !inst_valid_q || bus.inst_ready;
    assign hit       = valid_q[pc_idx] && tag_mem[pc_idx] == pc_tag;
    assign fill      = state_q == MISS && bus.mc_if_done;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else if (rdy) state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == RUN ? ((!bus.jump_en && slot_free && !hit) ? MISS : RUN)
                                 : (bus.mc_if_done ? RUN : MISS);
    end
    always_comb begin
        bus.mc_if_en = state_q == MISS;
        bus.mc_if_pc = miss_addr_q;
    end
    // A jump discards any same-cycle hit; a pending miss keeps running until its fill lands.
    always_comb begin
        pc_d         = pc_q;
        miss_addr_d  = miss_addr_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        if (bus.jump_en) begin
            pc_d         = {bus.jump_pc[31:2], 2'b00};
            inst_valid_d = 1'b0;
        end else if (state_q == RUN && slot_free) begin
            inst_valid_d = hit;
            if (hit) begin
                inst_data_d = data_mem[pc_idx];
                inst_pc_d   = pc_q;
                pc_d        = pc_q + 32'd4;
            end else begin
                miss_addr_d = {pc_q[31:2], 2'b00};
            end
        end else if (state_q == MISS && bus.inst_ready) begin
            inst_valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            miss_addr_q  <= '0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
            valid_q      <= '0;
        end else if (rdy) begin
            pc_q         <= pc_d;
            miss_addr_q  <= miss_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
            if (fill) valid_q[miss_idx] <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rdy && fill) begin
            data_mem[miss_idx] <= bus.mc_if_data;
            tag_mem[miss_idx]  <= miss_tag;
        end
    end
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_data  = inst_data_q;
    assign bus.inst_pc    = inst_pc_q;
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed fetch scenarios with hand-computed expectations.
module tb_ifetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   total = 0;
    int   bad = 0;
    ifetch_if bus();
    ifetch #(.ICACHE_LINES(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .bus(bus.master)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h0 ? 32'h00500093 : {a[23:0], 8'h13};
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // Entered on the negedge right after the miss edge; leaves on the negedge showing the issued word.
    task automatic fetch_miss(input logic [31:0] a, input int lat);
        check("req_en", {31'b0, bus.mc_if_en}, 32'd1);
        check("req_pc", bus.mc_if_pc, a);
        repeat (lat - 1) begin
            @(negedge clk);
            check("hold_pc", bus.mc_if_pc, a);
        end
        bus.mc_if_done = 1'b1;
        bus.mc_if_data = mem(a);
        @(negedge clk);
        bus.mc_if_done = 1'b0;
        check("fill_en", {31'b0, bus.mc_if_en}, 32'd0);
        @(negedge clk);
        check("iss_valid", {31'b0, bus.inst_valid}, 32'd1);
        check("iss_pc", bus.inst_pc, a);
        check("iss_data", bus.inst_data, mem(a));
    endtask
    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end
    initial begin
        bus.mc_if_done = 1'b0;
        bus.mc_if_data = '0;
        bus.jump_en    = 1'b0;
        bus.jump_pc    = '0;
        bus.inst_ready = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_en", {31'b0, bus.mc_if_en}, 32'd0);
        check("rst_mpc", bus.mc_if_pc, 32'h0);
        check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_data", bus.inst_data, 32'h0);
        check("rst_ipc", bus.inst_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("cold_valid", {31'b0, bus.inst_valid}, 32'd0);
        fetch_miss(32'h0, 4);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            fetch_miss(32'(i * 4), 2);
        end
        @(negedge clk);
        check("m10_pc", bus.mc_if_pc, 32'h10);
        bus.jump_en    = 1'b1;
        bus.jump_pc    = 32'h0;
        bus.mc_if_done = 1'b1;
        bus.mc_if_data = mem(32'h10);
        @(negedge clk);
        bus.jump_en    = 1'b0;
        bus.mc_if_done = 1'b0;
        check("jd_en", {31'b0, bus.mc_if_en}, 32'd0);
        check("jd_valid", {31'b0, bus.inst_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("loop_valid", {31'b0, bus.inst_valid}, 32'd1);
            check("loop_pc", bus.inst_pc, 32'(i * 4));
            check("loop_en", {31'b0, bus.mc_if_en}, 32'd0);
        end
        bus.jump_en = 1'b1;
        bus.jump_pc = 32'h0;
        @(negedge clk);
        bus.jump_en = 1'b0;
        check("jv_valid", {31'b0, bus.inst_valid}, 32'd0);
        @(negedge clk);
        check("re0_pc", bus.inst_pc, 32'h0);
        @(negedge clk);
        check("re4_pc", bus.inst_pc, 32'h4);
        @(negedge clk);
        check("re8_pc", bus.inst_pc, 32'h8);
        bus.inst_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", {31'b0, bus.inst_valid}, 32'd1);
            check("stall_pc", bus.inst_pc, 32'h8);
            check("stall_data", bus.inst_data, mem(32'h8));
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        check("resume_pc", bus.inst_pc, 32'hC);
        bus.jump_en = 1'b1;
        bus.jump_pc = 32'h40;
        @(negedge clk);
        bus.jump_en = 1'b0;
        check("j40_valid", {31'b0, bus.inst_valid}, 32'd0);
        @(negedge clk);
        check("alias_en", {31'b0, bus.mc_if_en}, 32'd1);
        check("alias_pc", bus.mc_if_pc, 32'h40);
        @(negedge clk);
        check("m40_pc1", bus.mc_if_pc, 32'h40);
        bus.jump_en = 1'b1;
        bus.jump_pc = 32'h100;
        @(negedge clk);
        bus.jump_en = 1'b0;
        check("m40_pc2", bus.mc_if_pc, 32'h40);
        check("m40_en", {31'b0, bus.mc_if_en}, 32'd1);
        check("m40_valid", {31'b0, bus.inst_valid}, 32'd0);
        bus.mc_if_done = 1'b1;
        bus.mc_if_data = mem(32'h40);
        @(negedge clk);
        bus.mc_if_done = 1'b0;
        check("f40_en", {31'b0, bus.mc_if_en}, 32'd0);
        check("f40_valid", {31'b0, bus.inst_valid}, 32'd0);
        @(negedge clk);
        check("r100_valid", {31'b0, bus.inst_valid}, 32'd0);
        fetch_miss(32'h100, 2);
        @(negedge clk);
        check("m104_pc", bus.mc_if_pc, 32'h104);
        rdy = 1'b0;
        bus.mc_if_done = 1'b1;
        bus.mc_if_data = mem(32'h104);
        @(negedge clk);
        check("frz_en", {31'b0, bus.mc_if_en}, 32'd1);
        check("frz_pc", bus.mc_if_pc, 32'h104);
        check("frz_ipc", bus.inst_pc, 32'h100);
        rdy = 1'b1;
        bus.jump_en = 1'b1;
        bus.jump_pc = 32'h0;
        @(negedge clk);
        bus.jump_en    = 1'b0;
        bus.mc_if_done = 1'b0;
        check("jd2_en", {31'b0, bus.mc_if_en}, 32'd0);
        @(negedge clk);
        check("refetch_en", {31'b0, bus.mc_if_en}, 32'd1);
        check("refetch_pc", bus.mc_if_pc, 32'h0);
        fetch_miss(32'h0, 2);
        @(negedge clk);
        check("m4_pc", bus.mc_if_pc, 32'h4);
        #2 rst = 1'b0;
        #1;
        check("arst_en", {31'b0, bus.mc_if_en}, 32'd0);
        check("arst_mpc", bus.mc_if_pc, 32'h0);
        check("arst_data", bus.inst_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        bus.mc_if_done = 1'b1;
        bus.mc_if_data = 32'hDEADBEEF;
        @(negedge clk);
        bus.mc_if_done = 1'b0;
        check("stray_valid", {31'b0, bus.inst_valid}, 32'd0);
        fetch_miss(32'h0, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter: ICACHE_LINES, default 16, number of direct-mapped one-word lines (power of 2, 2..256).
REQ-002 Parameter: RESET_PC, default 32'h0, fetch address after reset.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-005 Port: rdy  in  1  global enable; 0 = freeze all state.
REQ-006 Port: mc_if_en  out  1  fetch request to the memory controller.
REQ-007 Port: mc_if_pc  out  32  word address of the request.
REQ-008 Port: mc_if_data  in  32  returned instruction, little-endian, valid with mc_if_done.
REQ-009 Port: mc_if_done  in  1  one-cycle completion pulse from the memory controller.
REQ-010 Port: jump_en  in  1  redirect/flush strobe.
REQ-011 Port: jump_pc  in  32  redirect target.
REQ-012 Port: inst_valid  out  1  instruction slot holds a valid instruction.
REQ-013 Port: inst_ready  in  1  downstream accepts the slot this cycle.
REQ-014 Port: inst_data  out  32  instruction word.
REQ-015 Port: inst_pc  out  32  address of inst_data.

Function
REQ-016 Cache shall be direct-mapped: index = pc[IDX+1:2], tag = pc[17:IDX+2], IDX = log2(ICACHE_LINES); one valid bit per line; pc[31:18] ignored for lookup.
REQ-017 Internal registers: pc (next fetch address), miss_addr, state in {RUN, MISS}.
REQ-018 Slot free = !inst_valid or (inst_valid and inst_ready).
REQ-019 RUN, slot free, no jump, hit: at the next edge, inst_data = cached word, inst_pc = pc, inst_valid = 1, pc = pc + 4 (mod 2^32); one instruction per cycle on consecutive hits.
REQ-020 RUN, slot free, no jump, miss: at the next edge, miss_addr = {pc[31:2],2'b00}, mc_if_pc = miss_addr, mc_if_en = 1, state = MISS; if the slot was consumed, inst_valid = 0.
REQ-021 RUN, slot not free: no lookup; pc and slot hold.
REQ-022 MISS: mc_if_en and mc_if_pc shall hold until mc_if_done is sampled high; at that edge, line[miss_addr index] = mc_if_data with tag and valid set, mc_if_en = 0, state = RUN; the instruction is issued by the following RUN lookup (hit).
REQ-023 mc_if_en shall never be 1 in RUN; at most one request is outstanding.
REQ-024 In MISS the output slot still handshakes: a consumed slot clears inst_valid.
REQ-025 jump_en = 1 (any state): at the next edge, pc = {jump_pc[31:2],2'b00}, inst_valid = 0; any same-cycle hit is discarded and pc is not incremented.
REQ-026 jump_en in MISS: state stays MISS; the outstanding request completes and fills the cache at miss_addr; then RUN resumes at the new pc.
REQ-027 jump_en with simultaneous mc_if_done in MISS: fill performed, state = RUN, pc = jump target.
REQ-028 jump_en with simultaneous inst_valid & inst_ready: the handshake counts as accepted; the slot is then cleared.
REQ-029 rdy = 0: no register, cache line or valid bit changes; outputs hold.
REQ-030 Cache contents persist across jumps; only reset clears valid bits.

Reset
REQ-031 rst = 0 shall immediately (asynchronously) force: mc_if_en = 0, mc_if_pc = 0, inst_valid = 0, inst_data = 0, inst_pc = 0, pc = RESET_PC, miss_addr = 0, state = RUN, all valid bits = 0.
REQ-032 Reset during MISS shall abandon the request; a late mc_if_done after reset release in RUN shall be ignored.
REQ-033 The first lookup occurs at the first rising edge with rst = 1 and rdy = 1.

Verification
REQ-034 Cold start, RESET_PC = 0, memory[0] = 32'h00500093, inst_ready = 1 -> mc_if_en = 1, mc_if_pc = 0; done pulse 4 cycles later; next cycle inst_valid = 1, inst_data = 32'h00500093, inst_pc = 0.
REQ-035 Loop 0x0..0xC pre-filled, inst_ready = 1 -> four consecutive cycles of inst_valid, inst_pc 0, 4, 8, C; mc_if_en stays 0.
REQ-036 Miss at 0x40, jump_en with jump_pc = 0x100 two cycles later -> mc_if_pc stays 0x40 until done; line for 0x40 filled; next request mc_if_pc = 0x100; no instruction from 0x40 issued.
REQ-037 inst_ready = 0 for 3 cycles with inst_valid = 1, inst_pc = 0x8 -> inst_data and inst_pc stable; pc not advanced; resumes at 0xC on release.
REQ-038 Aliasing, ICACHE_LINES = 16: fetch 0x0 then 0x40 -> second access misses and replaces the line; refetch 0x0 misses again.
REQ-039 rst = 0 asserted mid-MISS between edges -> outputs clear without a clock edge; a stray mc_if_done after release is ignored and the fetch restarts at RESET_PC.
